mc_sequencer: RTL
=================

Name: mc_sequencer

Overview:
Multicycle instruction sequencer for the MIPS core.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath write enables, mux selects and the memory request handshake.
- Sits between the instruction register output (`inst`) and the datapath, alongside the combinational control decoder.
- Supervises memory waits with a timeout, and supports stall from the hazard/debug logic.

Parameters:
- MEM_TIMEOUT, 16: cycles a memory request may wait for `mem_ready` before abort; legal range 2..255.
- CNT_W, 8: width of the internal wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  current instruction register contents; opcode is inst[31:26].
- stall  in  1  freeze sequencer.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- mem_req  out  1  memory request.
- mem_wr  out  1  1 = write (store), 0 = read.
- iord  out  1  address select: 0 = PC, 1 = ALU result.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC write.
- pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
- alu_src_b  out  1  ALU operand B: 0 = register, 1 = sign-extended immediate.
- rf_we  out  1  register file write.
- rf_dst_sel  out  1  destination register: 0 = rt, 1 = rd.
- rf_wdata_sel  out  1  register write data: 0 = ALU, 1 = memory.
- illegal  out  1  one-cycle pulse on undefined opcode.
- bus_err  out  1  one-cycle pulse on memory timeout.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset state: state = FETCH, wait counter = 0; all outputs 0 during and in the cycle after reset.
- Output style:
  - Outputs are Moore from state.
  - ir_we, pc_we and the FETCH/MEM exit are Mealy-qualified by mem_ready or alu_zero, as stated per state below.
- Opcode classes:
  - RTYPE = 010010
  - LOAD = 010011
  - ALUI = 010100
  - STORE = 010101
  - BRANCH = 010110
  - JUMP = 010111
  - NOP = 000000
  - Any other opcode is ILLEGAL.
- FETCH:
  - mem_req = 1, mem_wr = 0, iord = 0.
  - When mem_ready = 1: ir_we = 1, pc_we = 1, pc_src = 0, next state DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: class register <= opcode class.
  - JUMP: pc_we = 1, pc_src = 2, next FETCH.
  - NOP: next FETCH, no side effects.
  - ILLEGAL: illegal = 1, next FETCH.
  - All other classes: next EXEC.
- EXEC: alu_src_b = 1 for ALUI/LOAD/STORE, 0 otherwise.
  - RTYPE/ALUI: next WB.
  - LOAD/STORE: next MEM.
  - BRANCH: pc_we = alu_zero, pc_src = 1, next FETCH.
- MEM:
  - mem_req = 1, iord = 1, mem_wr = (class == STORE).
  - When mem_ready = 1: STORE goes to FETCH, LOAD goes to WB.
  - Otherwise stay in MEM and count.
- WB:
  - rf_we = 1.
  - rf_dst_sel = 1 only for RTYPE.
  - rf_wdata_sel = 1 only for LOAD.
  - Next FETCH.
- Wait counter:
  - Cleared on every state change.
  - If it reaches MEM_TIMEOUT in FETCH or MEM with no mem_ready: bus_err = 1, mem_req deasserted that cycle, next FETCH. No register, PC or IR writes occur.
  - mem_ready arriving in the same cycle the count hits MEM_TIMEOUT counts as success; no bus_err.
- Stall (stall = 1):
  - State and counter are held.
  - mem_req, ir_we, pc_we and rf_we are forced to 0.
  - mem_ready is ignored.
  - Stall has priority over mem_ready and timeout.
- Reset mid-transaction: mem_req = 0 from the next edge; no completion is reported.
- Latency with zero wait states: JUMP 2, BRANCH 3, RTYPE/ALUI/STORE 4, LOAD 5 cycles.

Optional Feature:
- Macro: SEQ_PERF_EN.
- When defined, adds output ports:
  - cycle_cnt [31:0]: increments every non-reset cycle.
  - instr_cnt [31:0]: increments on each return to FETCH from a completed instruction, excluding ILLEGAL and bus_err.
  - stall_cnt [31:0]: counts cycles with stall = 1 or a memory wait.
  - All counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `seq_defs`:
  - opcode class constants;
  - state encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4;
  - pc_src encodings.
- Sub-module `mem_wait_timer`:
  - counter with clear, hold and terminal-count output;
  - parameterised by MEM_TIMEOUT and CNT_W.

Test Plan:
1. rst = 1 for 2 cycles, then mem_ready tied 1, inst = 32'b010010_00000_00001_00100_01010_110010 → states FETCH, DECODE, EXEC, WB; rf_we = 1 in WB with rf_dst_sel = 1; next instruction fetched on cycle 5.
2. inst = LOAD (010011_11111_00000_0x0000), mem_ready held low 3 cycles in MEM → mem_req = 1, iord = 1, mem_wr = 0 throughout; WB one cycle after mem_ready with rf_wdata_sel = 1.
3. mem_ready held 0 in FETCH with MEM_TIMEOUT = 4 → bus_err pulses exactly once after 4 wait cycles; ir_we and pc_we never assert; sequencer restarts FETCH.
4. inst = BRANCH with alu_zero = 1, then repeated with alu_zero = 0 → pc_we = 1 with pc_src = 1 in EXEC only in the first case; both return to FETCH after 3 cycles.
5. inst = 32'b000000… (NOP), then opcode 111111 → no write enables for the NOP; illegal pulses one cycle in DECODE for 111111.
6. stall = 1 for 3 cycles during MEM with mem_ready = 1 → state_o holds, mem_req = 0; completion occurs on the first cycle after stall falls.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_defs (package)
//  Brief    : State encoding, opcode classes and PC source encodings shared
//             by the multicycle sequencer and its wait timer.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_defs;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_FETCH  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_DECODE = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_EXEC   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_MEM    = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_WB     = 3'd4;

    localparam logic [5:0] c_OP_NOP    = 6'b000000;
    localparam logic [5:0] c_OP_RTYPE  = 6'b010010;
    localparam logic [5:0] c_OP_LOAD   = 6'b010011;
    localparam logic [5:0] c_OP_ALUI   = 6'b010100;
    localparam logic [5:0] c_OP_STORE  = 6'b010101;
    localparam logic [5:0] c_OP_BRANCH = 6'b010110;
    localparam logic [5:0] c_OP_JUMP   = 6'b010111;

    localparam logic [1:0] c_PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] c_PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_ALUI    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_JUMP    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } inst_class_e;

    function automatic inst_class_e decode_class(input logic [5:0] opcode);
        inst_class_e cls;
        case (opcode)
            c_OP_NOP:    cls = CLS_NOP;
            c_OP_RTYPE:  cls = CLS_RTYPE;
            c_OP_LOAD:   cls = CLS_LOAD;
            c_OP_ALUI:   cls = CLS_ALUI;
            c_OP_STORE:  cls = CLS_STORE;
            c_OP_BRANCH: cls = CLS_BRANCH;
            c_OP_JUMP:   cls = CLS_JUMP;
            default:     cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Brief    : Memory wait counter with clear, hold and terminal-count flag.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic hold_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] c_TC = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Hold beats clear so a stalled wait resumes exactly where it stopped.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (hold_i) begin
            w_cnt_d = r_cnt_q;
        end else if (clr_i) begin
            w_cnt_d = '0;
        end else if (r_cnt_q != c_TC) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign tc_o = (r_cnt_q == c_TC);

endmodule
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mc_sequencer
//  Brief    : Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
//             timeout and stall. Define SEQ_PERF_EN for performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_sequencer
    import seq_defs::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic        rf_we,
    output logic        rf_dst_sel,
    output logic        rf_wdata_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [c_STATE_W-1:0] r_state_q;
    logic [c_STATE_W-1:0] w_state_d;
    inst_class_e          r_class_q;
    inst_class_e          w_dec_class;
    logic                 r_post_rst_q;
    logic                 w_freeze;
    logic                 w_active;
    logic                 w_wait_st;
    logic                 w_tc;
    logic                 w_timeout;
    logic                 w_unused_inst;

    assign w_dec_class   = decode_class(inst[31:26]);
    assign w_unused_inst = ^inst[25:0];

    // The cycle after reset is frozen so every output stays low for it.
    assign w_freeze  = stall | r_post_rst_q;
    assign w_active  = ~w_freeze;
    assign w_wait_st = (r_state_q == c_ST_FETCH) || (r_state_q == c_ST_MEM);
    assign w_timeout = w_active && w_wait_st && !mem_ready && w_tc;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!(w_wait_st && !mem_ready) || w_tc),
        .hold_i (w_freeze),
        .tc_o   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_FETCH;
            r_class_q    <= CLS_NOP;
            r_post_rst_q <= 1'b1;
        end else begin
            r_post_rst_q <= 1'b0;
            r_state_q    <= w_state_d;
            if ((r_state_q == c_ST_DECODE) && w_active) begin
                r_class_q <= w_dec_class;
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        if (w_active) begin
            case (r_state_q)
                c_ST_FETCH: begin
                    if (mem_ready) begin
                        w_state_d = c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    case (w_dec_class)
                        CLS_JUMP, CLS_NOP, CLS_ILLEGAL: w_state_d = c_ST_FETCH;
                        default:                        w_state_d = c_ST_EXEC;
                    endcase
                end
                c_ST_EXEC: begin
                    case (r_class_q)
                        CLS_RTYPE, CLS_ALUI: w_state_d = c_ST_WB;
                        CLS_LOAD, CLS_STORE: w_state_d = c_ST_MEM;
                        default:             w_state_d = c_ST_FETCH;
                    endcase
                end
                c_ST_MEM: begin
                    if (mem_ready) begin
                        w_state_d = (r_class_q == CLS_STORE) ? c_ST_FETCH : c_ST_WB;
                    end else if (w_tc) begin
                        w_state_d = c_ST_FETCH;
                    end
                end
                default: w_state_d = c_ST_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        iord         = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = c_PCSRC_SEQ;
        alu_src_b    = 1'b0;
        rf_we        = 1'b0;
        rf_dst_sel   = 1'b0;
        rf_wdata_sel = 1'b0;
        illegal      = 1'b0;
        bus_err      = 1'b0;
        case (r_state_q)
            c_ST_FETCH: begin
                mem_req = w_active && !w_timeout;
                ir_we   = w_active && mem_ready;
                pc_we   = w_active && mem_ready;
                bus_err = w_timeout;
            end
            c_ST_DECODE: begin
                if (w_dec_class == CLS_JUMP) begin
                    pc_src = c_PCSRC_JUMP;
                    pc_we  = w_active;
                end
                illegal = w_active && (w_dec_class == CLS_ILLEGAL);
            end
            c_ST_EXEC: begin
                alu_src_b = (r_class_q == CLS_ALUI) || (r_class_q == CLS_LOAD) ||
                            (r_class_q == CLS_STORE);
                if (r_class_q == CLS_BRANCH) begin
                    pc_src = c_PCSRC_BRANCH;
                    pc_we  = w_active && alu_zero;
                end
            end
            c_ST_MEM: begin
                mem_req = w_active && !w_timeout;
                iord    = 1'b1;
                mem_wr  = (r_class_q == CLS_STORE);
                bus_err = w_timeout;
            end
            c_ST_WB: begin
                rf_we        = w_active;
                rf_dst_sel   = (r_class_q == CLS_RTYPE);
                rf_wdata_sel = (r_class_q == CLS_LOAD);
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign state_o = r_state_q;

`ifdef SEQ_PERF_EN
    logic w_instr_done;
    logic w_wait_cycle;

    // Illegal opcodes and aborted transactions do not count as retired.
    assign w_instr_done = w_active && (w_state_d == c_ST_FETCH) &&
                          (r_state_q != c_ST_FETCH) && !w_timeout &&
                          !((r_state_q == c_ST_DECODE) && (w_dec_class == CLS_ILLEGAL));
    assign w_wait_cycle = stall || (w_active && w_wait_st && !mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (w_instr_done) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
            if (w_wait_cycle) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
